// File: rtl/ov5640_cfg_seq_pkg.sv
// ov5640_cfg_pkg: shared types and constants for the OV5640 register-init sequencer
package ov5640_cfg_pkg;
  localparam logic [7:0] OV_WR_ID = 8'h78;
  localparam logic [7:0] OV_RD_ID = 8'h79;
  typedef enum logic [3:0] {PWR_WAIT, LOAD, START, WAIT_HI, WAIT_LO, GAP, CHECK, DONE, ERR} state_e;
  typedef struct packed {
    logic [7:0]  id;
    logic [15:0] addr;
    logic [7:0]  data;
  } wdata_t;
endpackage

// File: rtl/ov5640_cfg_seq_if.sv
// ov5640_cfg_seq_if: sequencer <-> IIC master bus (master = sequencer side: start/wdata out, busy/iic_data in)
interface ov5640_cfg_seq_if;
  logic        start;
  logic [31:0] wdata;
  logic        busy;
  logic [7:0]  iic_data;
  modport master (output start, wdata, input busy, iic_data);
  modport slave (input start, wdata, output busy, iic_data);
endinterface

// File: rtl/ov5640_cfg_seq_rom.sv
// ov5640_cfg_rom: registered init table, addr_i -> q_o = {reg_addr[15:0], data[7:0]} one clk later
module ov5640_cfg_rom (
  input  logic        clk,
  input  logic [7:0]  addr_i,
  output logic [23:0] q_o
);
  always_ff @(posedge clk)
    case (addr_i)
      8'd0:    q_o <= 24'h310311;
      8'd1:    q_o <= 24'h300882;
      8'd2:    q_o <= 24'h300842;
      8'd3:    q_o <= 24'h310303;
      8'd4:    q_o <= 24'h3017ff;
      8'd5:    q_o <= 24'h3018ff;
      8'd6:    q_o <= 24'h30341a;
      8'd7:    q_o <= 24'h303713;
      8'd8:    q_o <= 24'h310801;
      8'd9:    q_o <= 24'h363036;
      8'd10:   q_o <= 24'h36310e;
      8'd11:   q_o <= 24'h3632e2;
      default: q_o <= 24'h300802;
    endcase
endmodule

// File: rtl/ov5640_cfg_seq.sv
// ov5640_cfg_seq: OV5640 power-up register-init sequencer feeding an SCCB/IIC master.
// Ports: clk, rst_n (sync active-low), reinit_i (restart pulse), bus (master modport: start/wdata out,
// busy/iic_data in), cfg_idx_o (entry in flight), cfg_done_o (table written), cfg_err_o (sticky error).
// Optional: OV5640_CFG_READBACK_EN adds a readback-and-compare read after every write.
module ov5640_cfg_seq
  import ov5640_cfg_pkg::*;
#(
  parameter int CFG_NUM   = 252,
  parameter int PWRUP_DLY = 1000000,
  parameter int GAP_DLY   = 500,
  parameter int BUSY_TO   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reinit_i,
  ov5640_cfg_seq_if.master      bus,
  output logic [7:0]            cfg_idx_o,
  output logic                  cfg_done_o,
  output logic                  cfg_err_o
);
  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  wdata_t      wdata_q, wdata_d;
  logic [7:0]  idx_q, idx_d;
  logic [23:0] rom_q;
`ifdef OV5640_CFG_READBACK_EN
  logic        rd_q, rd_d;
`else
  logic        unused_iic;
  assign unused_iic = ^bus.iic_data;
`endif
  ov5640_cfg_rom u_rom (.clk(clk), .addr_i(idx_q), .q_o(rom_q));
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= PWR_WAIT;
      cnt_q   <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
`ifdef OV5640_CFG_READBACK_EN
      rd_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      idx_q   <= idx_d;
`ifdef OV5640_CFG_READBACK_EN
      rd_q    <= rd_d;
`endif
    end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 32'd1;
    wdata_d = wdata_q;
    idx_d   = idx_q;
`ifdef OV5640_CFG_READBACK_EN
    rd_d    = rd_q;
`endif
    case (state_q)
      PWR_WAIT: if (cnt_q == 32'(PWRUP_DLY - 1)) begin
        state_d = LOAD;
        cnt_d   = '0;
      end
      // second LOAD cycle: ROM output for the current index is valid
      LOAD: if (cnt_q[0]) begin
        wdata_d = {OV_WR_ID, rom_q};
        state_d = START;
      end
      // hold off while a previous (e.g. pre-reinit) frame is still running; cnt counts cycles since start
      START: if (!bus.busy) begin
        state_d = WAIT_HI;
        cnt_d   = 32'd1;
      end
      WAIT_HI: state_d = bus.busy ? WAIT_LO : (cnt_q == 32'(BUSY_TO - 1)) ? ERR : WAIT_HI;
      WAIT_LO: if (!bus.busy) begin
        cnt_d   = '0;
`ifdef OV5640_CFG_READBACK_EN
        state_d = rd_q ? CHECK : START;
        if (!rd_q) begin
          rd_d    = 1'b1;
          wdata_d = {OV_RD_ID, wdata_q.addr, 8'h00};
        end
`else
        state_d = GAP;
`endif
      end
`ifdef OV5640_CFG_READBACK_EN
      // rom_q still holds the entry just written since idx has not moved
      CHECK: begin
        cnt_d   = '0;
        rd_d    = 1'b0;
        state_d = (bus.iic_data != rom_q[7:0]) ? ERR : GAP;
      end
`endif
      GAP: if (cnt_q == 32'(GAP_DLY - 1)) begin
        cnt_d   = '0;
        state_d = (idx_q == 8'(CFG_NUM - 1)) ? DONE : LOAD;
        idx_d   = (idx_q == 8'(CFG_NUM - 1)) ? idx_q : idx_q + 8'd1;
      end
      default: ;
    endcase
    if (reinit_i) begin
      state_d = PWR_WAIT;
      cnt_d   = '0;
      idx_d   = '0;
`ifdef OV5640_CFG_READBACK_EN
      rd_d    = 1'b0;
`endif
    end
  end
  assign bus.start  = (state_q == START) && !bus.busy;
  assign bus.wdata  = wdata_q;
  assign cfg_idx_o  = idx_q;
  assign cfg_done_o = (state_q == DONE);
  assign cfg_err_o  = (state_q == ERR);
endmodule

// File: tb/tb_ov5640_cfg_seq.sv
// tb_ov5640_cfg_seq: scoreboard bench for ov5640_cfg_seq with a behavioural IIC master model
module tb_ov5640_cfg_seq;
  localparam int CFG_NUM = 3;
  localparam int PWRUP   = 10;
  localparam int GAP     = 20;
  localparam int BTO     = 16;
  localparam int BLEN    = 40;
`ifdef OV5640_CFG_READBACK_EN
  localparam int TPE = 2;
`else
  localparam int TPE = 1;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic reinit = 1'b0;
  logic [7:0] cfg_idx;
  logic cfg_done, cfg_err;
  ov5640_cfg_seq_if bus();
  ov5640_cfg_seq #(.CFG_NUM(CFG_NUM), .PWRUP_DLY(PWRUP), .GAP_DLY(GAP), .BUSY_TO(BTO)) dut (
    .clk(clk), .rst_n(rst_n), .reinit_i(reinit), .bus(bus.master),
    .cfg_idx_o(cfg_idx), .cfg_done_o(cfg_done), .cfg_err_o(cfg_err)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  logic [23:0] rom_exp [0:2] = '{24'h310311, 24'h300882, 24'h300842};
  int mode = 0;
  int n_start = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push_seq();
    for (int i = 0; i < CFG_NUM; i++) begin
      exp_q.push_back({8'h78, rom_exp[i]});
      if (TPE == 2) exp_q.push_back({8'h79, rom_exp[i][23:8], 8'h00});
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    reinit = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_start", bus.start, 0);
    check("rst_wdata", bus.wdata, 0);
    check("rst_idx", cfg_idx, 0);
    check("rst_done", cfg_done, 0);
    check("rst_err", cfg_err, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic wait_end(input int limit);
    int k = 0;
    while (!(cfg_done || cfg_err) && k < limit) begin
      @(negedge clk);
      k++;
    end
    check("end_in_time", k < limit, 1);
  endtask
  task automatic wait_start(input int limit);
    int k = 0;
    @(negedge clk);
    while (!bus.start && k < limit) begin
      @(negedge clk);
      k++;
    end
    check("start_in_time", k < limit, 1);
  endtask
  // IIC master model: busy one cycle after start, BLEN cycles long; reads return the last written byte
  logic [31:0] frame;
  logic [7:0]  last_wr = 8'h00;
  int wr_cnt = 0;
  initial begin
    bus.busy = 1'b0;
    bus.iic_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) wr_cnt = 0;
      else if (bus.start && mode != 1) begin
        frame = bus.wdata;
        @(posedge clk);
        #1 bus.busy = 1'b1;
        repeat (BLEN) @(posedge clk);
        #1 bus.busy = 1'b0;
        if (frame[24]) bus.iic_data = last_wr ^ {7'd0, (mode == 2 && wr_cnt == 3)};
        else begin
          last_wr = frame[7:0];
          wr_cnt++;
        end
      end
    end
  end
  // monitor: pops the scoreboard on every start, checks spacing and wdata stability per frame
  int last_start = -1;
  logic [31:0] cap = '0;
  bit in_frame = 0, orphan = 0, stable = 1, was_busy = 0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      last_start = -1;
      in_frame = 0;
      orphan = 0;
    end else begin
      if (reinit) begin
        last_start = -1;
        orphan = in_frame;
      end
      if (in_frame) begin
        if (bus.wdata !== cap) stable = 0;
        if (bus.busy) was_busy = 1;
        else if (was_busy) begin
          if (!orphan) check("wdata_stable", stable, 1);
          in_frame = 0;
          orphan = 0;
          was_busy = 0;
        end
      end
      if (bus.start) begin
        check("start_bus_idle", bus.busy, 0);
        if (exp_q.size() == 0) check("start_expected", 0, 1);
        else check("wdata", bus.wdata, exp_q.pop_front());
        if (last_start >= 0 && bus.wdata[31:24] == 8'h78)
          check("start_spacing", (cyc - last_start) >= BLEN + GAP + 3, 1);
        last_start = cyc;
        n_start++;
        cap = bus.wdata;
        stable = 1;
        was_busy = 0;
        in_frame = 1;
      end
    end
  end
  initial begin
    int s0, t0, k;
    mode = 0;
    do_reset();
    s0 = n_start;
    push_seq();
    wait_end(4000);
    check("a_done", cfg_done, 1);
    check("a_err", cfg_err, 0);
    check("a_idx", cfg_idx, CFG_NUM - 1);
    check("a_starts", n_start - s0, CFG_NUM * TPE);
    check("a_sb_empty", exp_q.size(), 0);
    mode = 1;
    do_reset();
    s0 = n_start;
    exp_q.push_back({8'h78, rom_exp[0]});
    wait_start(200);
    t0 = cyc;
    k = 0;
    while (!cfg_err && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("b_err_latency", cyc - t0, BTO);
    repeat (50) @(negedge clk);
    check("b_err", cfg_err, 1);
    check("b_done", cfg_done, 0);
    check("b_starts", n_start - s0, 1);
    check("b_sb_empty", exp_q.size(), 0);
    mode = 0;
    do_reset();
    push_seq();
    k = 0;
    while (!(cfg_idx == 8'd1 && bus.busy) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("c_reached_entry1", k < 2000, 1);
    exp_q.delete();
    push_seq();
    @(posedge clk);
    #1 reinit = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1 reinit = 1'b0;
    @(negedge clk);
    check("c_idx", cfg_idx, 0);
    check("c_done", cfg_done, 0);
    check("c_err", cfg_err, 0);
    check("c_start", bus.start, 0);
    wait_start(500);
    check("c_pwrup_gap", (cyc - t0) >= PWRUP, 1);
    wait_end(4000);
    check("c_done_end", cfg_done, 1);
    check("c_sb_empty", exp_q.size(), 0);
`ifdef OV5640_CFG_READBACK_EN
    mode = 2;
    do_reset();
    s0 = n_start;
    push_seq();
    wait_end(4000);
    check("d_err", cfg_err, 1);
    check("d_done", cfg_done, 0);
    check("d_idx", cfg_idx, 2);
    check("d_starts", n_start - s0, 6);
`endif
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
